// File: rtl/scan_host_pkg.sv
// scan_host_pkg: shared widths and the sequencer state type for the scan host.
//   SCAN_IN_W  - packed DUT input vector carried in the wrapper's input cells
//   SCAN_OUT_W - captured {idle, dout[31:0]}
//   SCAN_W     - total wrapper chain length (outputs first, then inputs)
//   RUN_W      - width of the free-running cycle count
package scan_host_pkg;

  localparam int SCAN_IN_W   = 47;
  localparam int SCAN_OUT_W  = 33;
  localparam int SCAN_W      = 80;
  localparam int RUN_W       = 16;
  localparam int SHIFT_CNT_W = 7;

  localparam logic [SHIFT_CNT_W-1:0] SHIFT_LAST = SHIFT_CNT_W'(SCAN_W - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    TAIL    = 3'd3,
    RUN     = 3'd4
  } state_t;

endpackage

// File: rtl/scan_host_if.sv
// scan_host_if: transaction-side bus of the scan host.
//   req        - start one transaction (taken only while busy=0)
//   in_vec     - packed DUT inputs applied through the chain
//   run_cycles - number of DUT clock enables after the shift
//   busy       - transaction in flight
//   out_vec    - captured {idle, dout}
//   out_valid  - one-cycle pulse when out_vec updates
//   echo_err   - sticky echo-mismatch flag
// master: transaction issuer; slave: scan_host.
interface scan_host_if;
  import scan_host_pkg::*;

  logic                  req;
  logic [SCAN_IN_W-1:0]  in_vec;
  logic [RUN_W-1:0]      run_cycles;
  logic                  busy;
  logic [SCAN_OUT_W-1:0] out_vec;
  logic                  out_valid;
  logic                  echo_err;

  modport master (
    output req, in_vec, run_cycles,
    input  busy, out_vec, out_valid, echo_err
  );

  modport slave (
    input  req, in_vec, run_cycles,
    output busy, out_vec, out_valid, echo_err
  );

endinterface

// File: rtl/scan_host.sv
// scan_host: drives a scan wrapper through CAPTURE / SHIFT / TAIL / RUN.
// Each transaction captures the DUT outputs, shifts the new input vector in
// while the old chain contents come out, then lets the DUT run for
// run_cycles enables. The value returned therefore reflects the DUT state
// left by the previous transaction's RUN phase.
//   clk, rst - single clock, synchronous active-high reset
//   host     - transaction bus (scan_host_if.slave)
//   tc, ts   - wrapper capture / shift controls (registered)
//   di       - serial data into the chain (registered)
//   do_in    - wrapper's registered serial output
module scan_host
  import scan_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  scan_host_if.slave  host,
  output logic        tc,
  output logic        ts,
  output logic        di,
  input  logic        do_in
);

  state_t                 state, nxt;
  logic [SHIFT_CNT_W-1:0] shift_cnt;
  logic [RUN_W-1:0]       run_cnt;
  logic [RUN_W-1:0]       run_len;
  logic [SCAN_W-1:0]      tx_sr;
  logic [SCAN_W-1:0]      rx_sr;
  logic [SCAN_IN_W-1:0]   cur_vec;
  logic [SCAN_IN_W-1:0]   prev_vec;
  logic [SCAN_OUT_W-1:0]  out_vec_q;
  logic                   out_valid_q;
  logic                   echo_err_q;
  logic                   echo_vld;
  logic                   accept;
  logic                   shift_last;
  logic                   run_last;
  logic                   tc_d, ts_d, di_d;

  assign accept     = host.req && (state == IDLE);
  assign shift_last = (shift_cnt == SHIFT_LAST);
  assign run_last   = (run_cnt == (run_len - 1'b1));

  assign host.busy      = (state != IDLE);
  assign host.out_vec   = out_vec_q;
  assign host.out_valid = out_valid_q;
  assign host.echo_err  = echo_err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = CAPTURE;
      CAPTURE: nxt = SHIFT;
      SHIFT:   if (shift_last) nxt = TAIL;
      TAIL:    nxt = (run_len != '0) ? RUN : IDLE;
      RUN:     if (run_last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output decode from the next state so the wrapper pins come straight
  // from flops and line up with the state they belong to.
  always_comb begin
    tc_d = 1'b1;
    ts_d = 1'b0;
    di_d = 1'b0;
    case (nxt)
      SHIFT: begin
        tc_d = 1'b0;
        ts_d = 1'b1;
        di_d = tx_sr[SCAN_W-1];
      end
      RUN:     tc_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= 1'b1;
      ts <= 1'b0;
      di <= 1'b0;
    end else begin
      tc <= tc_d;
      ts <= ts_d;
      di <= di_d;
    end
  end

  // Phase counters; both sit at zero outside their own phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt <= '0;
      run_cnt   <= '0;
    end else begin
      shift_cnt <= (state == SHIFT && !shift_last) ? shift_cnt + 1'b1 : '0;
      run_cnt   <= (state == RUN && !run_last)     ? run_cnt + 1'b1   : '0;
    end
  end

  // Data path: transmit/receive shift registers and latched request.
  // tx_sr holds the sequence {33 zeros, in_vec} with the next bit at the MSB;
  // it advances whenever the following cycle is a shift cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      cur_vec <= host.in_vec;
      run_len <= host.run_cycles;
      tx_sr   <= {{SCAN_OUT_W{1'b0}}, host.in_vec};
    end else if (nxt == SHIFT) begin
      tx_sr   <= tx_sr << 1;
    end
    if (state == SHIFT) rx_sr <= {rx_sr[SCAN_W-2:0], do_in};
    if (state == TAIL)  prev_vec <= cur_vec;
  end

  // Result and echo check at the end of TAIL. rx_sr[79] is the first sample
  // (idle), rx_sr[46:0] is the input vector applied by the prior transaction.
  // echo_vld is cleared by reset because an aborted shift leaves the chain
  // contents meaningless.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      echo_err_q  <= 1'b0;
      echo_vld    <= 1'b0;
    end else begin
      out_valid_q <= (state == TAIL);
      if (state == TAIL) begin
        out_vec_q <= rx_sr[SCAN_W-1 -: SCAN_OUT_W];
        if (echo_vld && (rx_sr[SCAN_IN_W-1:0] != prev_vec)) echo_err_q <= 1'b1;
        echo_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/scan_host.md
SCAN_HOST -- requirements
Module: scan_host

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port req, input, 1, start one transaction; accepted only when busy=0.
REQ-004 SHALL have port in_vec, input, 47, packed DUT inputs {rst,din[31:0],ds[3:0],wr_i,wr_c,wr_x,rounds[3:0],start,rd_r,rd_c}, MSB first; sampled on accepted req.
REQ-005 SHALL have port run_cycles, input, 16, number of free-running DUT clock enables; sampled on accepted req.
REQ-006 SHALL have port busy, output, 1, high from accept until the transaction completes.
REQ-007 SHALL have port out_vec, output, 33, captured {idle,dout[31:0]}.
REQ-008 SHALL have port out_valid, output, 1, one-cycle pulse when out_vec updates.
REQ-009 SHALL have port echo_err, output, 1, sticky echo-mismatch flag.
REQ-010 SHALL have ports tc, ts, di, outputs, 1 each, driven from flops, to the scan wrapper.
REQ-011 SHALL have port do_in, input, 1, the wrapper's registered serial output.

Function
REQ-012 SHALL implement states IDLE, CAPTURE, SHIFT, TAIL, RUN.
REQ-013 IDLE: tc=1, ts=0, di=0 (DUT frozen); req with busy=0 -> CAPTURE on the next cycle, latching in_vec and run_cycles.
REQ-014 CAPTURE: exactly 1 cycle, tc=1, ts=0 -> SHIFT.
REQ-015 SHIFT: exactly 80 cycles, tc=0, ts=1; in shift cycle k (0..79), di = bit k of the sequence {33 zeros, in_vec[46] down to in_vec[0]} -> TAIL.
REQ-016 TAIL: 1 cycle, tc=1, ts=0 -> RUN if latched run_cycles>0, else IDLE.
REQ-017 RUN: tc=0, ts=0 for exactly run_cycles cycles -> IDLE; DUT therefore advances exactly run_cycles edges.
REQ-018 SHALL sample do_in into an 80-bit receive shift register at the edge ending each of SHIFT cycles 0..79 (80 samples, one-cycle lag accounted for by the wrapper's do flop); first sample = idle, next 32 = dout[31:0] MSB first, last 47 = previously applied in_vec MSB first.
REQ-019 At TAIL exit SHALL load out_vec from the first 33 samples and pulse out_valid for 1 cycle.
REQ-020 The result returned by a transaction SHALL reflect the DUT state after the previous transaction's RUN; this SHALL be documented behaviour, not an error.
REQ-021 SHALL compare the last 47 samples with the in_vec of the previous transaction and set echo_err on mismatch; the compare SHALL be skipped for the first transaction after reset.
REQ-022 echo_err SHALL stay set until rst.
REQ-023 busy SHALL be high from the cycle after accept through the final RUN cycle, or through TAIL when run_cycles=0.
REQ-024 req while busy=1 SHALL be ignored; there is no queueing.
REQ-025 The shift counter SHALL be 7 bits, terminal at 79; the run counter SHALL be 16 bits, with run_cycles=16'hFFFF giving 65535 RUN cycles.

Reset
REQ-026 rst SHALL take effect in any state, including mid-SHIFT or mid-RUN, and return the block to IDLE on the next cycle.
REQ-027 After rst: tc=1, ts=0, di=0, busy=0, out_valid=0, out_vec=0, echo_err=0, counters=0, echo-valid flag=0.
REQ-028 An aborted shift SHALL leave the wrapper chain undefined; the next transaction SHALL skip the echo compare.

Structure
REQ-029 A shared package SHALL hold SCAN_IN_W=47, SCAN_OUT_W=33, SCAN_W=80, RUN_W=16, and the state enum.
REQ-030 scan_host SHALL be a single module with no sub-module; the bench SHALL instantiate the existing scan wrapper and core as the partner.

Verification
REQ-031 Reset, then req with in_vec=0 and run_cycles=0 -> busy for 82 cycles; out_valid once; echo not checked; echo_err=0.
REQ-032 Two back-to-back requests, with in_vec=47'h1234_5678_9AB and then in_vec=0 -> second transaction's echo samples equal 47'h1234_5678_9AB; echo_err=0.
REQ-033 Force one do_in bit low during the echo field -> echo_err=1 and remains 1 until rst.
REQ-034 run_cycles=5 -> tc=ts=0 for exactly 5 cycles; the wrapper clk_en is high on exactly 5 edges.
REQ-035 Assert rst at SHIFT cycle 40 -> IDLE next cycle with tc=1 and ts=0; the following transaction's echo is skipped.
REQ-036 Load the core to produce dout=32'hDEADBEEF with idle=1 -> the next transaction returns out_vec=33'h1_DEADBEEF.
